mips_mem_arbiter: RTL
=====================

Name: mips_mem_arbiter

Overview:
- Shares the single-ported 1024x32 unified memory of the pipelined MIPS32 core between two requesters: the instruction-fetch port (IF, read-only) and the data port (MEM stage, LW/SW).
- Performs one memory access per cycle. The data port has priority, with a starvation guard that forces an IF grant.
- Routes the synchronous-read response back to the owning port. Supports cancelling an in-flight fetch on a taken branch.
- Keeps a saturating IF-stall counter for performance analysis.

Parameters:
- ADDR_W, 10, word-address width (1024 words).
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while IF waits before IF is forced through (legal range 1..15).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; held until if_gnt.
- if_addr  in  ADDR_W  IF word address.
- if_gnt  out  1  IF request accepted this cycle (combinational).
- if_flush  in  1  taken branch: cancel IF response due this cycle.
- if_rvalid  out  1  IF read data valid.
- if_rdata  out  DATA_W  IF read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read with mem_en=1.
- if_stall_cnt  out  CNT_W  cycles with if_req=1 and if_gnt=0, saturating.

Behaviour:
- Reset (asynchronous, immediate):
  - State = ARB_DPRI; starve_cnt = 0; resp_owner = NONE.
  - if_rvalid = 0, d_rvalid = 0, if_stall_cnt = 0.
  - mem_en = 0 and both gnt = 0 while rst is high.
  - if_rdata and d_rdata read 0 while their rvalid is 0.
- Grant logic (combinational in cycle t), two-state FSM:
  - ARB_DPRI: d_req wins; otherwise if_req wins.
  - ARB_IFPRI: if_req wins; otherwise d_req wins.
  - Exactly one gnt when any req is high. No gnt and mem_en = 0 when both reqs are low.
- Memory drive:
  - The granted port's address (and d_we/d_wdata for data) go to mem_* in the grant cycle, with mem_en = 1.
  - IF grants always drive mem_we = 0.
- Response timing:
  - resp_owner register records IF_RD, D_RD or NONE at the grant edge. Stores record NONE.
  - At t+1, the owner's rvalid = 1 and its rdata = mem_rdata. Other port: rvalid = 0, rdata = 0.
  - Read latency is exactly 1 cycle after grant. Stores produce no response.
  - Back-to-back grants every cycle are supported.
- Flush: if if_flush = 1 in the cycle an IF response is due, if_rvalid is forced to 0. if_flush has no effect on data responses or current grants.
- Starvation counter starve_cnt (4 bits):
  - Increments when d_gnt=1 and if_req=1.
  - Clears on any if_gnt, or when if_req=0.
  - At STARVE_LIMIT, the FSM moves ARB_DPRI -> ARB_IFPRI at the next edge.
  - ARB_IFPRI -> ARB_DPRI after the first if_gnt, or if if_req drops. starve_cnt clears on the exit.
- Stall counter: if_stall_cnt increments each cycle with if_req & ~if_gnt. It holds at 2^CNT_W-1 (no wrap).
- Simultaneous events:
  - Both reqs in ARB_DPRI -> data granted, IF stalls.
  - A store and a fetch of the same address in consecutive cycles -> the fetch sees the new value (ordered by grant).
- Reset mid-operation: a pending response is dropped. No rvalid is asserted after rst deassertion until a new grant.

Decomposition:
- Shared package mips_mem_pkg:
  - ADDR_W/DATA_W defaults.
  - Owner encoding NONE=2'b00, IF_RD=2'b01, D_RD=2'b10.
  - FSM encoding ARB_DPRI=1'b0, ARB_IFPRI=1'b1.
- One sub-module: mips_sat_counter (parameterised width, inc, saturating), used for if_stall_cnt.

Test Plan:
- Only if_req, addr 5, Mem[5]=32'h28010078 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=32'h28010078; if_stall_cnt=0.
- Both reqs for one cycle: d_we=1, d_addr=121, wdata=130; if_addr=121 -> d_gnt first, IF granted next cycle; if_rdata=130; if_stall_cnt=1.
- d_req continuous (loads 120..) with if_req held, STARVE_LIMIT=4 -> 4 d_gnts, then one if_gnt, then data resumes; if_stall_cnt=4.
- IF granted at t with if_flush=1 at t+1 -> if_rvalid stays 0; a d_rvalid in the following cycle is unaffected.
- rst asserted the cycle after a D_RD grant -> d_rvalid never asserts; all outputs 0; state ARB_DPRI after release.
- CNT_W=4, if_req held, d_req held and STARVE_LIMIT=15 -> if_stall_cnt reaches 15 and holds at 15.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS32 unified-memory arbiter: default widths,
// response-owner encoding and arbiter FSM encoding.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    // Which port owns the read response due in the next cycle.
    typedef enum logic [1:0] {
        NONE  = 2'b00,
        IF_RD = 2'b01,
        D_RD  = 2'b10
    } owner_e;

    typedef enum logic {
        ARB_DPRI  = 1'b0,
        ARB_IFPRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mips_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and holds at all-ones.
module mips_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Increment unless already at the maximum value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-ported memory arbiter between the IF (read-only) and MEM-stage data
// ports. Data has priority; a starvation guard forces an IF grant after
// STARVE_LIMIT consecutive data grants while IF waits. Read data returns one
// cycle after the grant to whichever port owned the access.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    input  logic              if_flush,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  if_stall_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state, state_d;
    logic [3:0] starve_cnt, starve_cnt_d;
    owner_e     resp_owner, resp_owner_d;

    // Grant decode and memory drive; nothing is granted while in reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (state == ARB_DPRI) begin
                d_gnt  = d_req;
                if_gnt = if_req & ~d_req;
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req & ~if_req;
            end
        end
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wdata = d_gnt ? d_wdata : '0;
    end

    // Next-state: response owner, starvation count and priority state.
    always_comb begin
        resp_owner_d = NONE;
        if (if_gnt) begin
            resp_owner_d = IF_RD;
        end else if (d_gnt && !d_we) begin
            resp_owner_d = D_RD;
        end

        starve_cnt_d = starve_cnt;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt != 4'hf)) begin
            starve_cnt_d = starve_cnt + 4'd1;
        end

        state_d = state;
        if (state == ARB_DPRI) begin
            // Use the post-grant count so IF wins right after the LIMIT-th data grant.
            if (starve_cnt_d >= LIMIT) begin
                state_d = ARB_IFPRI;
            end
        end else if (if_gnt || !if_req) begin
            state_d      = ARB_DPRI;
            starve_cnt_d = '0;
        end
    end

    // Arbiter state registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_DPRI;
            starve_cnt <= '0;
            resp_owner <= NONE;
        end else begin
            state      <= state_d;
            starve_cnt <= starve_cnt_d;
            resp_owner <= resp_owner_d;
        end
    end

    // Route the synchronous-read data to the owner; a taken branch kills the fetch.
    always_comb begin
        if_rvalid = (resp_owner == IF_RD) & ~if_flush;
        d_rvalid  = (resp_owner == D_RD);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

    mips_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_req & ~if_gnt),
        .count (if_stall_cnt)
    );

endmodule
